// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-port memory arbiter.
// State encoding, port index type and default widths.
package mem_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef logic port_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
// On a tie the port that was not served last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last,
    output logic       grant_valid,
    output port_t      grant_idx
);

    // Pick the single requester, or alternate on a tie.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        unique case (req)
            2'b11:   grant_idx = ~last;
            2'b10:   grant_idx = 1'b1;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory between CPU (port 0) and aux (port 1).
// Optional MEM_ARB_LOCK_EN adds lock1 so port 1 can keep the memory across bursts.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
`ifdef MEM_ARB_LOCK_EN
    input  logic          lock1,
`endif
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t    state;
    port_t         owner;
    port_t         last;
    logic [1:0]    req_v;
    logic          pick_valid;
    port_t         pick_idx;
    logic          go;
    port_t         gidx;
    logic          sel_we;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_wdata;
`ifdef MEM_ARB_LOCK_EN
    logic          locked;
    logic          hold;
`endif

    assign req_v = {req1, req0};
    assign busy  = (state != IDLE);

    rr_pick2 u_pick (
        .req         (req_v),
        .last        (last),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    assign sel_we    = gidx ? we1    : we0;
    assign sel_adr   = gidx ? adr1   : adr0;
    assign sel_wdata = gidx ? wdata1 : wdata0;

    // Decide whether a new grant starts this cycle, and for which port.
    always_comb begin
        go   = 1'b0;
        gidx = pick_idx;
`ifdef MEM_ARB_LOCK_EN
        hold = owner & lock1;
`endif
        unique case (state)
            IDLE: begin
                go   = pick_valid;
                gidx = pick_idx;
`ifdef MEM_ARB_LOCK_EN
                if (locked && req1) begin
                    go   = 1'b1;
                    gidx = 1'b1;
                end
`endif
            end
            DONE: begin
                // The owner's req is stale here; only the other port counts.
                gidx = ~owner;
                go   = owner ? req0 : req1;
`ifdef MEM_ARB_LOCK_EN
                if (hold) go = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Arbiter FSM with registered memory drive, acks and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifdef MEM_ARB_LOCK_EN
            locked    <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
`ifdef MEM_ARB_LOCK_EN
                    locked <= (state == DONE) && hold;
`endif
                    if (go) begin
                        owner     <= gidx;
                        mem_we    <= sel_we;
                        mem_adr   <= sel_adr;
                        mem_wdata <= sel_wdata;
                        state     <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (owner) begin
                        ack1 <= 1'b1;
                        if (!mem_we) rdata1 <= mem_rdata;
                    end else begin
                        ack0 <= 1'b1;
                        if (!mem_we) rdata0 <= mem_rdata;
                    end
                    mem_we <= 1'b0;
                    last   <= owner;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against
// a word-array memory model and per-port expected-transaction queues.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wdata0, adr1, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        busy;
`ifdef MEM_ARB_LOCK_EN
    logic        lock1;
`endif

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .adr0      (adr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .adr1      (adr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata1    (rdata1),
`ifdef MEM_ARB_LOCK_EN
        .lock1     (lock1),
`endif
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rd0, exp_rd1;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          wait0, wait1;
    bit          starve_chk = 1'b1;
    bit          mon_en = 1'b0;
    int          c, k, n0, n1, first_p;
    bit          seen;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_5A5A;
    endfunction

    // Simple 64-word memory device: combinational read, write on clock edge.
    logic [31:0] mem [64];
    bit          init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= (i == 16) ? 32'hDEAD_BEEF : init_word(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            mem[mem_adr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_adr[7:2]];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard side: pop the oldest expected transaction of the acked port.
    task automatic serve(input bit p);
        txn_t t;
        int   idx;
        if ((p && q1.size() == 0) || (!p && q0.size() == 0)) begin
            total_cnt++;
            $display("FAIL unexpected_ack%0d: got ack expected none", p);
            return;
        end
        if (p) t = q1.pop_front();
        else   t = q0.pop_front();
        idx = int'(t.adr[7:2]);
        if (!t.we) begin
            if (p) exp_rd1 = ref_mem[idx];
            else   exp_rd0 = ref_mem[idx];
        end else begin
            ref_mem[idx] = t.wdata;
        end
        if (p) check("rdata1", rdata1, exp_rd1);
        else   check("rdata0", rdata0, exp_rd0);
        if (starve_chk) begin
            if (p) begin
                wait1 = 0;
                if (q0.size() > 0) begin
                    wait0++;
                    check("starve0", 32'(wait0 <= 2), 32'd1);
                end
            end else begin
                wait0 = 0;
                if (q1.size() > 0) begin
                    wait1++;
                    check("starve1", 32'(wait1 <= 2), 32'd1);
                end
            end
        end
    endtask

    // Monitor: every ack is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack0 || ack1) check("ack_excl", 32'(ack0 & ack1), 32'd0);
            if (ack0) serve(1'b0);
            if (ack1) serve(1'b1);
        end
    end

    task automatic present(input bit p, input logic we, input logic [31:0] adr,
                           input logic [31:0] wd);
        txn_t t;
        t.we = we;
        t.adr = adr;
        t.wdata = wd;
        if (p) begin
            req1 = 1'b1; we1 = we; adr1 = adr; wdata1 = wd;
            q1.push_back(t);
        end else begin
            req0 = 1'b1; we0 = we; adr0 = adr; wdata0 = wd;
            q0.push_back(t);
        end
    endtask

    task automatic withdraw(input bit p);
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    task automatic wait_ack(input bit p, input int lim, output int cyc);
        cyc = -1;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (p ? ack1 : ack0) begin
                cyc = i;
                return;
            end
        end
        total_cnt++;
        $display("FAIL timeout_ack%0d: got no ack expected ack within %0d", p, lim);
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        exp_rd0 = '0;
        exp_rd1 = '0;
        wait0 = 0;
        wait1 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; adr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; adr1 = '0; wdata1 = '0;
`ifdef MEM_ARB_LOCK_EN
        lock1 = 1'b0;
`endif
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic port_proc(input bit p);
        int          cy;
        logic [31:0] a;
        for (int n = 0; n < 30; n++) begin
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            present(p, 1'($urandom_range(0, 1)), a, $urandom);
            wait_ack(p, 16, cy);
            if (cy < 0) break;
            if ($urandom_range(0, 1) == 1) begin
                withdraw(p);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        withdraw(p);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        ref_mem[16] = 32'hDEAD_BEEF;
        do_reset();
        mon_en = 1'b1;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_adr", mem_adr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);

        // Single CPU load.
        present(1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        check("t1_adr", mem_adr, 32'h40);
        check("t1_busy1", 32'(busy), 32'd1);
        check("t1_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("t1_ack0", 32'(ack0), 32'd1);
        check("t1_ack1", 32'(ack1), 32'd0);
        check("t1_busy2", 32'(busy), 32'd1);
        check("t1_rdata0", rdata0, 32'hDEAD_BEEF);
        withdraw(1'b0);
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_ackoff", 32'(ack0), 32'd0);

        // Aux store then CPU reads it back.
        present(1'b1, 1'b1, 32'h80, 32'h1234_5678);
        @(negedge clk);
        check("t2_we", 32'(mem_we), 32'd1);
        check("t2_adr", mem_adr, 32'h80);
        check("t2_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        check("t2_weoff", 32'(mem_we), 32'd0);
        check("t2_ack1", 32'(ack1), 32'd1);
        withdraw(1'b1);
        @(negedge clk);
        present(1'b0, 1'b0, 32'h80, 32'h0);
        wait_ack(1'b0, 6, c);
        check("t2_lat", 32'(c), 32'd2);
        check("t2_rd", rdata0, 32'h1234_5678);
        withdraw(1'b0);
        @(negedge clk);

        // Tie after reset, both ports held: acks alternate 0,1,0,1.
        do_reset();
        present(1'b0, 1'b0, 32'h44, 32'h0);
        present(1'b1, 1'b0, 32'h48, 32'h0);
        n0 = 1; n1 = 1; k = 0;
        for (int cy = 1; cy <= 20 && k < 4; cy++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                check("t3_order", 32'(ack1), 32'(k % 2));
                if (k == 0) check("t3_cyc0", 32'(cy), 32'd2);
                if (k == 1) check("t3_cyc1", 32'(cy), 32'd4);
                k++;
                if (ack1) begin
                    if (n1 < 2) begin
                        present(1'b1, 1'b0, 32'h4C, 32'h0);
                        n1++;
                    end else withdraw(1'b1);
                end else begin
                    if (n0 < 2) begin
                        present(1'b0, 1'b0, 32'h50, 32'h0);
                        n0++;
                    end else withdraw(1'b0);
                end
            end
        end
        check("t3_count", 32'(k), 32'd4);
        @(negedge clk);

        // Async reset during a store's ACCESS cycle.
        present(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);
        @(negedge clk);
        check("t4_we_pre", 32'(mem_we), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t4_we_drop", 32'(mem_we), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_noack", 32'(ack1), 32'd0);
        withdraw(1'b0);
        withdraw(1'b1);
        clear_model();
        @(negedge clk);
        @(negedge clk);
        check("t4_noack2", 32'(ack1), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        present(1'b0, 1'b0, 32'h20, 32'h0);
        present(1'b1, 1'b0, 32'h24, 32'h0);
        k = 0;
        first_p = -1;
        for (int cy = 1; cy <= 12 && k < 2; cy++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                if (k == 0) begin
                    first_p = int'(ack1);
                    check("t4_tie_port", 32'(ack1), 32'd0);
                    check("t4_tie_cyc", 32'(cy), 32'd2);
                    check("t4_nowrite", rdata0, init_word(8));
                end
                k++;
                withdraw(ack1);
            end
        end
        check("t4_count", 32'(k), 32'd2);
        @(negedge clk);

        // Port 1 request pulse during port 0's ACCESS is dropped.
        present(1'b0, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; adr1 = 32'h34; wdata1 = 32'hFFFF_0000;
        @(negedge clk);
        req1 = 1'b0;
        check("t5_ack0", 32'(ack0), 32'd1);
        check("t5_we", 32'(mem_we), 32'd0);
        withdraw(1'b0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack1) seen = 1'b1;
        end
        check("t5_no_ack1", 32'(seen), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);

`ifdef MEM_ARB_LOCK_EN
        // Locked burst from port 1 keeps port 0 out until the lock drops.
        do_reset();
        starve_chk = 1'b0;
        lock1 = 1'b1;
        present(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        present(1'b0, 1'b0, 32'h14, 32'h0);
        k = 0; n1 = 1;
        for (int cy = 1; cy <= 30 && k < 4; cy++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                check("lk_order", 32'(ack1), (k < 3) ? 32'd1 : 32'd0);
                k++;
                if (ack1) begin
                    if (n1 < 3) begin
                        present(1'b1, 1'b0, 32'h10 + 32'(4 * n1), 32'h0);
                        n1++;
                    end else begin
                        withdraw(1'b1);
                        lock1 = 1'b0;
                    end
                end else withdraw(1'b0);
            end
        end
        check("lk_count", 32'(k), 32'd4);
        lock1 = 1'b0;
        @(negedge clk);
        starve_chk = 1'b1;
`endif

        // Random traffic from both ports against the reference memory.
        do_reset();
        fork
            port_proc(1'b0);
            port_proc(1'b1);
        join
        repeat (4) @(negedge clk);
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single unified instruction/data memory between the multicycle ARM core (port 0) and an auxiliary master such as DMA or a debug loader (port 1).
- Sits between `arm`/aux and `memory`; drives the memory's MemWrite/Adr/WriteData and returns ReadData.
- Each granted transaction is one 32-bit word access.
- Round-robin fairness applies when both ports request in the same cycle.

Parameters:
- AW, 32, address width (byte address, word aligned).
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req0  in  1  port 0 (CPU) request.
- we0  in  1  port 0 write enable (1=store, 0=load).
- adr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- ack0  out  1  port 0 completion, 1-cycle pulse.
- rdata0  out  DW  port 0 read data, valid while ack0=1.
- req1, we1, adr1, wdata1, ack1, rdata1  same as above for port 1 (aux).
- mem_we  out  1  to memory MemWrite.
- mem_adr  out  AW  to memory Adr.
- mem_wdata  out  DW  to memory WriteData.
- mem_rdata  in  DW  from memory ReadData (combinational read of mem_adr).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, owner=0, last=1 (port 0 wins the first tie).
  - mem_we=0, mem_adr=0, mem_wdata=0.
  - ack0=ack1=0, rdata0=rdata1=0, busy=0.
  - Reset mid-transaction aborts it: no ack is issued, and mem_we drops immediately.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one reqN=1: owner=N, go to ACCESS.
  - Both requesting: owner = port != last, go to ACCESS.
  - On the transition edge, register mem_adr<=adrN, mem_wdata<=wdataN, mem_we<=weN.
- ACCESS (exactly 1 cycle):
  - Memory sees registered signals.
  - A write commits in the memory on the edge ending ACCESS.
  - On that edge: rdataN<=mem_rdata (loads only; stores leave rdataN unchanged), ackN<=1, mem_we<=0, last<=owner. Go to DONE.
- DONE (1 cycle):
  - ack of the owner = 1.
  - The owner's req is ignored this cycle, because the requester deasserts or re-presents req after seeing ack.
  - If the non-owner port's req=1: grant it directly (DONE->ACCESS, latch its fields).
  - Otherwise go to IDLE.
- Latency: req sampled in cycle 0, ACCESS in cycle 1, ack in cycle 2. Throughput is 1 word per 2 cycles with alternating ports, or 1 word per 3 cycles from a single port.
- Handshake rules:
  - A requester holds req/we/adr/wdata stable from req rise until the cycle after its ack.
  - ack is a one-cycle pulse; ack0 and ack1 are never high together.
  - req deasserted before grant: no transaction, no ack.
- Ordering and boundaries:
  - Widths are pass-through, with no address arithmetic; a misaligned address is forwarded unchanged.
  - Starvation bound: a continuously requesting port is granted within 2 transactions of the other port.
  - Simultaneous first requests after reset go to port 0.

Optional Feature:
- MEM_ARB_LOCK_EN
- Defined:
  - Extra input lock1 (1 bit).
  - If lock1=1 while port 1 is owner in DONE and req1 is re-asserted in the cycle after ack1, port 1 keeps ownership: DONE->IDLE->ACCESS for port 1, ignoring req0 and the round-robin.
  - The lock is released when lock1=0 at the DONE cycle; port 0 is then granted next if requesting.
- Undefined: the lock1 port is absent and arbitration is pure round-robin.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t.
  - typedef logic port_t (port index).
  - localparams ARB_AW=32, ARB_DW=32.
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: grant_valid, grant_idx.
  - Instantiated once in mem_arbiter.

Test Plan:
- Reset then single CPU load: req0=1, we0=0, adr0=0x40, memory[0x40]=0xDEADBEEF -> mem_adr=0x40 in cycle 1, ack0=1 with rdata0=0xDEADBEEF in cycle 2, busy 1 for 2 cycles, ack1 never high.
- Aux store: req1=1, we1=1, adr1=0x80, wdata1=0x12345678 -> mem_we=1 for exactly 1 cycle with mem_adr=0x80, ack1 in cycle 2; a following CPU load of 0x80 returns 0x12345678.
- Tie after reset: req0=req1=1, both loads -> port 0 ack at cycle 2, then DONE->ACCESS for port 1, with ack1 at cycle 4; both ports held high continuously produce alternating acks 0,1,0,1.
- Async reset mid-ACCESS: drop reset during ACCESS of a store -> mem_we=0 immediately, no ack, state IDLE; after release, the first tie goes to port 0.
- MEM_ARB_LOCK_EN: lock1=1, port 1 issues 3 back-to-back loads while req0=1 -> three ack1 pulses before any ack0; then lock1=0 -> next grant goes to port 0.
- Early withdrawal: req1 pulses for 1 cycle while port 0 is owner in ACCESS -> no port 1 transaction, no ack1, mem_we unaffected.
